// File: rtl/data_memory.sv
// Byte-addressable MEM-stage data memory with sized loads/stores and a clear engine.
// Optional debug read port enabled by defining MEM_DEBUG_PORT_EN.
module data_memory #(
    parameter  int DATA_BUS = 32,
    parameter  int LENGTH   = 256,
    localparam int BYTES    = DATA_BUS / 8,
    localparam int IDX_W    = $clog2(LENGTH),
    localparam int OFF_W    = $clog2(BYTES),
    localparam int ADDR_W   = IDX_W + OFF_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_rd_en,
    input  logic                i_wr_en,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    input  logic [DATA_BUS-1:0] i_data,
    input  logic                i_clear,
    output logic [DATA_BUS-1:0] o_data,
    output logic                o_valid,
    output logic                o_misaligned,
    output logic                o_busy
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [IDX_W-1:0]    i_dbg_addr,
    output logic [DATA_BUS-1:0] o_dbg_data
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [IDX_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    w_cnt_nx;
    logic [DATA_BUS-1:0] r_data;
    logic                r_valid;
    logic                r_mis;
    logic [DATA_BUS-1:0] r_mem [DEPTH];

    logic [IDX_W-1:0]    w_idx;
    logic [OFF_W-1:0]    w_off;
    logic [2:0]          w_amask;
    logic [7:0]          w_be_base;
    logic [BYTES-1:0]    w_be;
    logic [DATA_BUS-1:0] w_wdata;
    logic [DATA_BUS-1:0] w_shift;
    logic [DATA_BUS-1:0] w_keep;
    logic [DATA_BUS-1:0] w_ext;
    logic                w_sign;
    logic                w_mis;
    logic                w_acc;
    logic                w_store;
    logic                w_load;
    logic                w_mis_ev;
    logic                w_clr_we;

    assign w_idx   = i_addr[ADDR_W-1:OFF_W];
    assign w_off   = i_addr[OFF_W-1:0];
    assign w_wdata = i_data << {w_off, 3'b000};
    assign w_shift = r_mem[w_idx] >> {w_off, 3'b000};
    assign w_be    = BYTES'(w_be_base << w_off);

    // Size decode: alignment mask, byte lanes and extension point.
    always_comb begin
        w_amask   = 3'b000;
        w_be_base = 8'h01;
        w_keep    = '1;
        w_sign    = 1'b0;
        unique case (i_size)
            2'd0: begin
                w_amask   = 3'b000;
                w_be_base = 8'h01;
                w_keep    = DATA_BUS'(64'hFF);
                w_sign    = w_shift[7];
            end
            2'd1: begin
                w_amask   = 3'b001;
                w_be_base = 8'h03;
                w_keep    = DATA_BUS'(64'hFFFF);
                w_sign    = w_shift[15];
            end
            2'd2: begin
                w_amask   = 3'b011;
                w_be_base = 8'h0F;
                w_keep    = DATA_BUS'(64'hFFFF_FFFF);
                w_sign    = w_shift[31];
            end
            2'd3: begin
                w_amask   = 3'b111;
                w_be_base = 8'hFF;
                w_keep    = '1;
                w_sign    = w_shift[DATA_BUS-1];
            end
        endcase
    end

    assign w_ext = (w_shift & w_keep)
                 | ((!i_unsigned && w_sign) ? ~w_keep : '0);

    assign w_mis = ((3'(w_off) & w_amask) != 3'b000)
                 || (i_size == 2'd3 && DATA_BUS == 32);

    // A same-cycle clear wins over any request.
    assign w_acc    = (r_state == ST_IDLE) && !i_clear && (i_rd_en || i_wr_en);
    assign w_store  = w_acc && i_wr_en && !w_mis;
    assign w_load   = w_acc && !i_wr_en && !w_mis;
    assign w_mis_ev = w_acc && w_mis;
    assign w_clr_we = (r_state == ST_CLEAR) && rst;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            ST_CLEAR: begin
                w_cnt_nx = r_cnt + 1'b1;
                if (r_cnt == '1)
                    w_state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_clear) begin
                    w_state_nx = ST_CLEAR;
                    w_cnt_nx   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_valid <= w_load;
            r_mis   <= w_mis_ev;
            if (w_load)
                r_data <= w_ext;
        end
    end

    // Array is never reset; it is zeroed only by the clear engine.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_store) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_misaligned = r_mis;
    assign o_busy       = (r_state == ST_CLEAR);

`ifdef MEM_DEBUG_PORT_EN
    logic [DATA_BUS-1:0] r_dbg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_dbg <= '0;
        else
            r_dbg <= r_mem[i_dbg_addr];
    end

    assign o_dbg_data = r_dbg;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory (DATA_BUS=32, LENGTH=8).
// Debug-port vectors run only when MEM_DEBUG_PORT_EN is defined.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  i_addr;
    logic        i_rd_en;
    logic        i_wr_en;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_data;
    logic        i_clear;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_misaligned;
    logic        o_busy;
`ifdef MEM_DEBUG_PORT_EN
    logic [2:0]  i_dbg_addr;
    logic [31:0] o_dbg_data;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [32:0] q_exp [$];
    string       q_nm  [$];

    data_memory #(
        .DATA_BUS(32),
        .LENGTH  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (i_addr),
        .i_rd_en     (i_rd_en),
        .i_wr_en     (i_wr_en),
        .i_size      (i_size),
        .i_unsigned  (i_unsigned),
        .i_data      (i_data),
        .i_clear     (i_clear),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_misaligned(o_misaligned),
        .o_busy      (o_busy)
`ifdef MEM_DEBUG_PORT_EN
        ,
        .i_dbg_addr  (i_dbg_addr),
        .o_dbg_data  (o_dbg_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, required finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: every output pulse must match the head of the queue.
    always @(negedge clk) begin
        if (o_valid || o_misaligned) begin
            n_vec++;
            if (q_exp.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: valid=%0b mis=%0b data=%h, expected none",
                         o_valid, o_misaligned, o_data);
            end else begin
                logic [32:0] e;
                string       nm;
                e  = q_exp.pop_front();
                nm = q_nm.pop_front();
                if (o_misaligned !== e[32] || o_valid !== !e[32]
                    || (!e[32] && o_data !== e[31:0])) begin
                    n_err++;
                    $display("FAIL %s: got valid=%0b mis=%0b data=%h, expected valid=%0b mis=%0b data=%h",
                             nm, o_valid, o_misaligned, o_data, !e[32], e[32], e[31:0]);
                end
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [4:0] a, input logic [31:0] d);
        i_rd_en    = rd;
        i_wr_en    = wr;
        i_size     = sz;
        i_unsigned = uns;
        i_addr     = a;
        i_data     = d;
        @(posedge clk);
        #1;
        i_rd_en = 1'b0;
        i_wr_en = 1'b0;
    endtask

    task automatic ld(input logic [1:0] sz, input logic uns, input logic [4:0] a,
                      input logic [31:0] exp, input string nm);
        q_exp.push_back({1'b0, exp});
        q_nm.push_back(nm);
        drive(1'b1, 1'b0, sz, uns, a, 32'h0);
    endtask

    task automatic st(input logic [1:0] sz, input logic [4:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, sz, 1'b0, a, d);
    endtask

    task automatic bad(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [4:0] a, input string nm);
        q_exp.push_back({1'b1, 32'h0});
        q_nm.push_back(nm);
        drive(rd, wr, sz, 1'b0, a, 32'h1111_1111);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        rst        = 1'b0;
        i_addr     = '0;
        i_rd_en    = 1'b0;
        i_wr_en    = 1'b0;
        i_size     = 2'd0;
        i_unsigned = 1'b0;
        i_data     = '0;
        i_clear    = 1'b0;
`ifdef MEM_DEBUG_PORT_EN
        i_dbg_addr = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", o_data, 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_mis", 32'(o_misaligned), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h1);
        rst = 1'b1;
        wait_idle(n);
        chk("clear_len_por", 32'(n), 32'd8);

        ld(2'd2, 1'b0, 5'h14, 32'h0000_0000, "lw_14_zero");
        st(2'd2, 5'h04, 32'hDEAD_BEEF);
        ld(2'd0, 1'b0, 5'h07, 32'hFFFF_FFDE, "lb_07");
        ld(2'd0, 1'b1, 5'h07, 32'h0000_00DE, "lbu_07");
        ld(2'd1, 1'b0, 5'h04, 32'hFFFF_BEEF, "lh_04");
        ld(2'd1, 1'b1, 5'h06, 32'h0000_DEAD, "lhu_06");
        ld(2'd2, 1'b0, 5'h04, 32'hDEAD_BEEF, "lw_04");

        st(2'd0, 5'h0A, 32'hAAAA_AA12);
        ld(2'd2, 1'b0, 5'h08, 32'h0012_0000, "sb_0a");
        st(2'd0, 5'h09, 32'h5555_5534);
        ld(2'd2, 1'b0, 5'h08, 32'h0012_3400, "sb_09");
        ld(2'd0, 1'b0, 5'h09, 32'h0000_0034, "lb_09");

        bad(1'b1, 1'b0, 2'd1, 5'h03, "lh_03_mis");
        bad(1'b1, 1'b0, 2'd2, 5'h02, "lw_02_mis");
        bad(1'b1, 1'b0, 2'd3, 5'h00, "ld_00_mis");
        bad(1'b0, 1'b1, 2'd2, 5'h05, "sw_05_mis");
        ld(2'd2, 1'b0, 5'h04, 32'hDEAD_BEEF, "mis_no_write");

        drive(1'b1, 1'b1, 2'd2, 1'b0, 5'h0C, 32'h0102_0304);
        ld(2'd2, 1'b0, 5'h0C, 32'h0102_0304, "rdwr_is_store");
        st(2'd1, 5'h0E, 32'hFFFF_5678);
        ld(2'd2, 1'b0, 5'h0C, 32'h5678_0304, "sh_0e");
        ld(2'd1, 1'b0, 5'h0E, 32'h0000_5678, "lh_0e");
        ld(2'd2, 1'b0, 5'h2C, 32'h5678_0304, "wrap_2c");

`ifdef MEM_DEBUG_PORT_EN
        st(2'd2, 5'h08, 32'hCAFE_F00D);
        i_dbg_addr = 3'd2;
        @(posedge clk);
        #1;
        chk("dbg_idle", o_dbg_data, 32'hCAFE_F00D);
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        @(posedge clk);
        #1;
        chk("dbg_busy", o_dbg_data, 32'hCAFE_F00D);
        chk("dbg_busy_flag", 32'(o_busy), 32'h1);
        wait_idle(n);
        @(posedge clk);
        #1;
        chk("dbg_after_clear", o_dbg_data, 32'h0);
`endif

        st(2'd2, 5'h10, 32'h7777_7777);
        i_clear = 1'b1;
        drive(1'b0, 1'b1, 2'd2, 1'b0, 5'h00, 32'hFFFF_FFFF);
        chk("clear_busy", 32'(o_busy), 32'h1);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 5'h18, 32'hABCD_EF01);
        i_clear = 1'b0;
        drive(1'b1, 1'b0, 2'd2, 1'b0, 5'h14, 32'h0);
        wait_idle(n);
        chk("clear_len", 32'(n + 2), 32'd8);
        for (int w = 0; w < 8; w++)
            ld(2'd2, 1'b0, 5'(w * 4), 32'h0, $sformatf("cleared_w%0d", w));

        st(2'd2, 5'h1C, 32'h0000_0099);
        ld(2'd2, 1'b0, 5'h1C, 32'h0000_0099, "lw_1c");
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(o_busy), 32'h1);
        chk("rst_mid_data", o_data, 32'h0);
        chk("rst_mid_valid", 32'(o_valid), 32'h0);
        #3;
        rst = 1'b1;
        wait_idle(n);
        chk("clear_len_restart", 32'(n), 32'd8);
        ld(2'd2, 1'b0, 5'h1C, 32'h0, "restart_w7");
        ld(2'd2, 1'b0, 5'h10, 32'h0, "restart_w4");

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q_exp.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
